// File: rtl/imm_gen_pipe.sv
// Format-aware RV32I/RV64I immediate generator feeding a
// 2-entry in-order result queue with an illegal-opcode counter.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  logic [6:0]  opc;
  logic        is_i, is_s, is_b;
  logic        is_u, is_j, is_r;
  logic [31:0] raw;
  logic [2:0]  fmt_d;
  logic        ill_d;
  ent_t        dec;

  assign opc = in_instr[6:0];

  always_comb begin
    is_i = opc inside {7'b0000011, 7'b0010011,
                       7'b0011011, 7'b1100111,
                       7'b1110011};
    is_s = (opc == 7'b0100011);
    is_b = (opc == 7'b1100011);
    is_u = opc inside {7'b0110111, 7'b0010111};
    is_j = (opc == 7'b1101111);
    is_r = opc inside {7'b0110011, 7'b0111011,
                       7'b0001111};
  end

  // raw is already sign-extended to 32 bits
  always_comb begin
    raw   = '0;
    fmt_d = 3'd7;
    ill_d = 1'b0;
    unique case (1'b1)
      is_i: begin
        raw   = {{20{in_instr[31]}},
                 in_instr[31:20]};
        fmt_d = 3'd1;
      end
      is_s: begin
        raw   = {{20{in_instr[31]}},
                 in_instr[31:25],
                 in_instr[11:7]};
        fmt_d = 3'd2;
      end
      is_b: begin
        raw   = {{19{in_instr[31]}},
                 in_instr[31], in_instr[7],
                 in_instr[30:25],
                 in_instr[11:8], 1'b0};
        fmt_d = 3'd3;
      end
      is_u: begin
        raw   = {in_instr[31:12], 12'b0};
        fmt_d = 3'd4;
      end
      is_j: begin
        raw   = {{11{in_instr[31]}},
                 in_instr[31],
                 in_instr[19:12],
                 in_instr[20],
                 in_instr[30:21], 1'b0};
        fmt_d = 3'd5;
      end
      is_r: fmt_d = 3'd0;
      default: ill_d = 1'b1;
    endcase
  end

  always_comb begin
    dec.imm = XLEN'($signed(raw));
    dec.fmt = fmt_d;
    dec.ill = ill_d;
  end

  ent_t       mem [2];
  ent_t       head;
  logic       rd_ptr;
  logic       wr_idx;
  logic [1:0] count;
  logic       push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_idx    = rd_ptr ^ count[0];

  assign head        = mem[rd_ptr];
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_idx] <= dec;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && ill_d &&
                 illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, XLEN=32,
// backpressure, saturation and asynchronous reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_ill;
  logic [31:0] a_ins;
  logic [63:0] a_imm;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        b_iv, b_ir, b_ov, b_or, b_ill;
  logic [31:0] b_ins;
  logic [31:0] b_imm;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  logic        c_iv, c_ir, c_ov, c_or, c_ill;
  logic [31:0] c_ins;
  logic [63:0] c_imm;
  logic [2:0]  c_fmt;
  logic [1:0]  c_cnt;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_instr(a_ins),
    .out_valid(a_ov), .out_ready(a_or),
    .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill), .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_instr(b_ins),
    .out_valid(b_ov), .out_ready(b_or),
    .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill), .illegal_cnt(b_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) usat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_iv), .in_ready(c_ir),
    .in_instr(c_ins),
    .out_valid(c_ov), .out_ready(c_or),
    .out_imm(c_imm), .out_fmt(c_fmt),
    .out_illegal(c_ill), .illegal_cnt(c_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk_vec(input int i);
    string s;
    s = $sformatf("v%0d", i);
    chk({s, ".valid"}, 64'(a_ov), 64'd1);
    chk({s, ".imm"}, a_imm, vt[i].imm);
    chk({s, ".fmt"}, 64'(a_fmt), 64'(vt[i].fmt));
    chk({s, ".ill"}, 64'(a_ill), 64'(vt[i].ill));
    chk({s, ".cnt"}, 64'(a_cnt), 64'(vt[i].cnt));
    chk({s, ".in_ready"}, 64'(a_ir), 64'd1);
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 16'd0};
    vt[1]  = '{32'hFE20AE23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 16'd0};
    vt[2]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 16'd0};
    vt[3]  = '{32'h001000EF, 64'h0000000000000800, 3'd5, 1'b0, 16'd0};
    vt[4]  = '{32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0, 16'd0};
    vt[5]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 16'd0};
    vt[6]  = '{32'h00000000, 64'h0, 3'd7, 1'b1, 16'd1};
    vt[7]  = '{32'h00000033, 64'h0, 3'd0, 1'b0, 16'd1};
    vt[8]  = '{32'h40305093, 64'h0000000000000403, 3'd1, 1'b0, 16'd1};
    vt[9]  = '{32'h0000000F, 64'h0, 3'd0, 1'b0, 16'd1};
    vt[10] = '{32'h80000067, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0, 16'd1};
    vt[11] = '{32'h0000007F, 64'h0, 3'd7, 1'b1, 16'd2};
    vt[12] = '{32'h0000003B, 64'h0, 3'd0, 1'b0, 16'd2};
    vt[13] = '{32'h0000001B, 64'h0, 3'd1, 1'b0, 16'd2};
    vt[14] = '{32'h00000017, 64'h0, 3'd4, 1'b0, 16'd2};

    a_iv = 0; a_ins = '0; a_or = 1;
    b_iv = 0; b_ins = '0; b_or = 1;
    c_iv = 0; c_ins = '0; c_or = 1;
    rst_n = 0;
    #12;
    chk("rst.valid", 64'(a_ov), 64'd0);
    chk("rst.in_ready", 64'(a_ir), 64'd1);
    chk("rst.imm", a_imm, 64'd0);
    chk("rst.fmt", 64'(a_fmt), 64'd0);
    chk("rst.ill", 64'(a_ill), 64'd0);
    chk("rst.cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // decode table, one per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) chk_vec(i - 1);
      a_iv  = 1;
      a_ins = vt[i].instr;
    end
    @(negedge clk);
    chk_vec(NV - 1);
    a_iv = 0;
    @(negedge clk);
    chk("drain.valid", 64'(a_ov), 64'd0);

    // XLEN=32
    b_iv = 1; b_ins = 32'h800000B7;
    @(negedge clk);
    chk("x32.imm0", 64'(b_imm), 64'h80000000);
    chk("x32.fmt0", 64'(b_fmt), 64'd4);
    b_ins = 32'h123450B7;
    @(negedge clk);
    chk("x32.imm1", 64'(b_imm), 64'h12345000);
    chk("x32.fmt1", 64'(b_fmt), 64'd4);
    b_ins = 32'hFFF00093;
    @(negedge clk);
    chk("x32.imm2", 64'(b_imm), 64'hFFFFFFFF);
    b_iv = 0;

    // backpressure: 3 presented, 2 accepted
    a_or = 0;
    a_iv = 1; a_ins = 32'h00100093;
    @(negedge clk);
    chk("bp.ready1", 64'(a_ir), 64'd1);
    a_ins = 32'h00200093;
    @(negedge clk);
    chk("bp.ready2", 64'(a_ir), 64'd0);
    a_ins = 32'h00300093;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp.stall_ready", 64'(a_ir), 64'd0);
      chk("bp.stall_valid", 64'(a_ov), 64'd1);
      chk("bp.stall_imm", a_imm, 64'd1);
      chk("bp.stall_fmt", 64'(a_fmt), 64'd1);
    end
    a_or = 1;
    @(negedge clk);
    chk("bp.head2", a_imm, 64'd2);
    chk("bp.ready_back", 64'(a_ir), 64'd1);
    // next edge: push 3 and pop 2 at count=1
    @(negedge clk);
    chk("pp.valid", 64'(a_ov), 64'd1);
    chk("pp.head3", a_imm, 64'd3);
    a_iv = 0;
    @(negedge clk);
    chk("pp.empty", 64'(a_ov), 64'd0);

    // saturation with CNT_W=2
    c_iv = 1; c_ins = 32'h0000007F;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat.cnt%0d", k),
          64'(c_cnt), 64'(k > 3 ? 3 : k));
      chk("sat.ill", 64'(c_ill), 64'd1);
    end
    c_iv = 0;

    // async reset with two entries queued
    a_or = 0;
    a_iv = 1; a_ins = 32'h0000007F;
    @(negedge clk);
    a_ins = 32'h00500093;
    @(negedge clk);
    a_iv = 0;
    chk("pre.ready", 64'(a_ir), 64'd0);
    chk("pre.cnt", 64'(a_cnt), 64'd3);
    #2 rst_n = 0;
    #1;
    chk("arst.valid", 64'(a_ov), 64'd0);
    chk("arst.cnt", 64'(a_cnt), 64'd0);
    chk("arst.ready", 64'(a_ir), 64'd1);
    chk("arst.imm", a_imm, 64'd0);
    chk("arst.sat_cnt", 64'(c_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1;
    a_or = 1;
    @(negedge clk);
    chk("post.valid", 64'(a_ov), 64'd0);
    a_iv = 1; a_ins = 32'h00700093;
    @(negedge clk);
    a_iv = 0;
    chk("post.imm", a_imm, 64'd7);
    chk("post.cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    chk("post.empty", 64'(a_ov), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
